sram_bus_arbiter: RTL
=====================

Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data requester.
- The data requester is fed by the load/store byte-lane logic (wstrb, size, aligned wdata).
- Sequences each transaction through address handshake, then data return, and routes the response to its owner.
- Sits between the CPU core and the SRAM-to-AXI bridge. One outstanding transaction at a time.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width; only 32 supported

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request, level, held until inst_addr_ok
inst_addr  in  ADDR_W  fetch address, word aligned
inst_addr_ok  out  1  fetch request accepted (one-cycle pulse)
inst_data_ok  out  1  fetch data valid on rdata (one-cycle pulse)
data_req  in  1  load/store request, level, held until data_addr_ok
data_wr  in  1  1=store, 0=load
data_size  in  2  00 byte, 01 halfword, 10 word
data_wstrb  in  4  byte enables for store
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  lane-aligned store data
data_addr_ok  out  1  data request accepted (pulse)
data_data_ok  out  1  load data valid / store completed (pulse)
rdata  out  DATA_W  return data, valid with inst_data_ok or data_data_ok
mem_req  out  1  request to memory port
mem_wr  out  1  write flag to memory port
mem_size  out  2  size to memory port
mem_wstrb  out  4  byte enables to memory port
mem_addr  out  ADDR_W  address to memory port
mem_wdata  out  DATA_W  write data to memory port
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory data/response valid
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (resetn=0, asynchronous):
  - FSM=IDLE, owner=INST, rr_last=INST.
  - All *_ok outputs and mem_req = 0.
  - mem_* payload registers = 0, rdata = 0.
- FSM states: IDLE -> REQ -> WAIT -> IDLE.
- IDLE:
  - If data_req or inst_req is high, select an owner: data wins when both are high (fixed priority).
  - Register the owner's payload into mem_* and go to REQ.
  - Inst payload is forced to mem_wr=0, size=10, wstrb=0000.
- REQ:
  - mem_req=1 with registered payload.
  - On mem_addr_ok=1: pulse the owner's *_addr_ok for exactly that cycle, drop mem_req next cycle, go to WAIT.
  - Payload is stable while mem_req=1.
- WAIT:
  - On mem_data_ok=1: pulse the owner's *_data_ok in the same cycle; rdata = mem_rdata (combinational pass-through); go to IDLE.
- Latency:
  - Request-to-mem_req is 1 cycle.
  - Best-case round trip is 3 cycles (IDLE sample, REQ with same-cycle mem_addr_ok, WAIT with same-cycle mem_data_ok).
  - No back-to-back acceptance; IDLE always costs one cycle.
- mem_addr_ok and mem_data_ok in the same cycle while in REQ:
  - addr_ok is honoured and the state moves to WAIT.
  - The memory port guarantees data_ok no earlier than the cycle after addr_ok.
- mem_data_ok outside WAIT is ignored. It never produces a pulse.
- A requester dropping its req in REQ is a protocol violation; the registered payload is still issued.
- Stores also return through data_data_ok; rdata is don't-care for stores.
- Reset mid-transaction: the FSM returns to IDLE immediately and no pulses are generated. The memory port shares resetn and discards its outstanding transaction.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requests are high in IDLE, grant the requester not in rr_last.
  - rr_last updates on each grant.
- Undefined:
  - Fixed data priority; rr_last register absent.

Decomposition:
- Shared package/defines holds:
  - MEM_BYTE/MEM_HALFWORD/MEM_WORD size codes (00/01/10).
  - FSM state encodings (IDLE=0, REQ=1, WAIT=2).
  - Owner codes (INST=0, DATA=1).
- No sub-module. Optionally a small arb_pick function in the package for grant selection.

Test Plan:
- inst_req only, addr 0xBFC00000; mem_addr_ok next cycle, mem_data_ok 2 cycles later with 0x24080001 -> inst_addr_ok one pulse, inst_data_ok one pulse with rdata=0x24080001, data_* pulses stay 0.
- inst_req and data_req (load word 0x80001004) both high in same cycle -> data granted first (mem_addr=0x80001004); inst issued after data_data_ok (macro off). With macro on and rr_last=DATA, inst is granted first.
- Store byte data_addr=0x80000003, wstrb=1000, wdata=0xAB000000 -> mem_wr=1, size=00, wstrb=1000, wdata unchanged; data_data_ok on mem_data_ok.
- mem_addr_ok held low 5 cycles -> mem_req and payload stable all 5 cycles; exactly one addr_ok pulse.
- Spurious mem_data_ok in IDLE and REQ -> no *_data_ok pulses.
- resetn low during WAIT -> all outputs 0 asynchronously; after release, next inst_req is serviced normally.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg: shared codes for the SRAM bus arbiter
//   MEM_* size codes, FSM state encoding, owner encoding and the grant picker.
package sram_bus_arbiter_pkg;

    localparam logic [1:0] MEM_BYTE     = 2'b00;
    localparam logic [1:0] MEM_HALFWORD = 2'b01;
    localparam logic [1:0] MEM_WORD     = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    // Data wins a tie unless rotation is enabled, in which case the tie
    // goes to whoever was not granted last.
    function automatic owner_e arb_pick(input logic inst_req, input logic data_req,
                                        input logic rr_en, input owner_e rr_last);
        if (inst_req && data_req && rr_en)
            return (rr_last == OWN_INST) ? OWN_DATA : OWN_INST;
        return data_req ? OWN_DATA : OWN_INST;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like memory port between fetch and load/store
//   clk, resetn              : clock, asynchronous active-low reset
//   inst_req/inst_addr       : fetch request (level, held until inst_addr_ok)
//   inst_addr_ok/inst_data_ok: fetch accept / data-return pulses
//   data_req/wr/size/wstrb/addr/wdata : load/store request (level)
//   data_addr_ok/data_data_ok: load/store accept / completion pulses
//   rdata                    : return data, valid with either *_data_ok
//   mem_req/wr/size/wstrb/addr/wdata  : registered request to the memory port
//   mem_addr_ok/data_ok/rdata: memory port handshake and read data
//   Macro ARB_ROUND_ROBIN_EN : alternate grants on a tie instead of data priority.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d, pick;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              any_req, addr_hs, data_hs;

    assign any_req = inst_req | data_req;
    assign addr_hs = (state_q == S_REQ) && mem_addr_ok;
    // mem_data_ok only counts in WAIT, so spurious responses never pulse.
    assign data_hs = (state_q == S_WAIT) && mem_data_ok;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e rr_last_q;

    assign pick = arb_pick(inst_req, data_req, 1'b1, rr_last_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rr_last_q <= OWN_INST;
        else if (state_q == S_IDLE && any_req)
            rr_last_q <= pick;
    end
`else
    assign pick = arb_pick(inst_req, data_req, 1'b0, OWN_INST);
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        size_d  = size_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: if (any_req) begin
                state_d = S_REQ;
                owner_d = pick;
                // Fetches are always plain word reads regardless of the data bus.
                wr_d    = (pick == OWN_DATA) ? data_wr    : 1'b0;
                size_d  = (pick == OWN_DATA) ? data_size  : MEM_WORD;
                wstrb_d = (pick == OWN_DATA) ? data_wstrb : 4'b0000;
                addr_d  = (pick == OWN_DATA) ? data_addr  : inst_addr;
                wdata_d = (pick == OWN_DATA) ? data_wdata : '0;
            end
            S_REQ:   state_d = mem_addr_ok ? S_WAIT : S_REQ;
            S_WAIT:  state_d = mem_data_ok ? S_IDLE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            owner_q <= OWN_INST;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            wstrb_q <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_req      = state_q == S_REQ;
    assign mem_wr       = wr_q;
    assign mem_size     = size_q;
    assign mem_wstrb    = wstrb_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign inst_addr_ok = addr_hs && (owner_q == OWN_INST);
    assign data_addr_ok = addr_hs && (owner_q == OWN_DATA);
    assign inst_data_ok = data_hs && (owner_q == OWN_INST);
    assign data_data_ok = data_hs && (owner_q == OWN_DATA);
    assign rdata        = data_hs ? mem_rdata : '0;

endmodule
